// File: rtl/snk_video_pkg.sv
// Purpose: shared 9-bit raster count type, default SNK timing constants, window decode helper.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package snk_video_pkg;

   typedef logic [8:0] cnt9_t;

   localparam cnt9_t CNT_MAX        = 9'h1FF;

   localparam cnt9_t DEF_H_PRELOAD  = 9'h080;
   localparam cnt9_t DEF_V_PRELOAD  = 9'h0F8;
   localparam cnt9_t DEF_HB_END     = 9'h0C0;
   localparam cnt9_t DEF_HB_START   = 9'h1C0;
   localparam cnt9_t DEF_HS_START   = 9'h088;
   localparam cnt9_t DEF_HS_END     = 9'h0A8;
   localparam cnt9_t DEF_VB_END     = 9'h110;
   localparam cnt9_t DEF_VB_START   = 9'h1F0;
   localparam cnt9_t DEF_VS_START   = 9'h0F8;
   localparam cnt9_t DEF_VS_END     = 9'h100;

   // Start-inclusive, end-exclusive unsigned window test.
   function automatic logic in_window(cnt9_t cnt, cnt9_t win_start, cnt9_t win_end);
      return (cnt >= win_start) && (cnt < win_end);
   endfunction

endpackage

// File: rtl/hv_window_decode.sv
// Purpose: flags whether a raster count lies inside a [start,end) window.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
module hv_window_decode
   import snk_video_pkg::*;
(
   input  cnt9_t cnt_i,
   input  cnt9_t start_i,
   input  cnt9_t end_i,
   output logic  in_win_o
);

   assign in_win_o = in_window(cnt_i, start_i, end_i);

endmodule

// File: rtl/snk_hv_timing_ctrl.sv
// Purpose: cascaded H/V preloadable raster counters with blank/sync windows, frame strobe, VBLANK IRQ latch.
// Latency: flags registered from next-count decode, so they change in the same Clk as hcnt/vcnt.
// Backpressure: ce_pix low or freeze high holds all counts and flags; irq_ack is always honoured.
// Optional feature macro HSYNC_ADJ_EN: adds signed hs_adj port shifting the hsync window, captured per frame.
module snk_hv_timing_ctrl
   import snk_video_pkg::*;
#(
   parameter cnt9_t H_PRELOAD = DEF_H_PRELOAD,
   parameter cnt9_t V_PRELOAD = DEF_V_PRELOAD,
   parameter cnt9_t HB_END    = DEF_HB_END,
   parameter cnt9_t HB_START  = DEF_HB_START,
   parameter cnt9_t HS_START  = DEF_HS_START,
   parameter cnt9_t HS_END    = DEF_HS_END,
   parameter cnt9_t VB_END    = DEF_VB_END,
   parameter cnt9_t VB_START  = DEF_VB_START,
   parameter cnt9_t VS_START  = DEF_VS_START,
   parameter cnt9_t VS_END    = DEF_VS_END
)
(
   input  logic              Clk,
   input  logic              Clear_bar,
   input  logic              ce_pix,
   input  logic              freeze,
   input  logic              irq_ack,
`ifdef HSYNC_ADJ_EN
   input  logic signed [3:0] hs_adj,
`endif
   output logic [8:0]        hcnt,
   output logic [8:0]        vcnt,
   output logic              hblank,
   output logic              hsync,
   output logic              vblank,
   output logic              vsync,
   output logic              frame_start,
   output logic              irq_vblank
);

   cnt9_t hcnt_q, hcnt_d;
   cnt9_t vcnt_q, vcnt_d;
   logic  hblank_q, hsync_q, vblank_q, vsync_q;
   logic  frame_start_q, frame_start_d;
   logic  irq_q, irq_d;
   logic  advance, h_wrap, v_adv;
   logic  h_active, hs_win, v_active, vs_win;
   cnt9_t hs_start, hs_end;

   // Counter chain next state: H counts on advance, V counts on the H ripple carry.
   always_comb begin
      advance       = ce_pix & ~freeze;
      h_wrap        = (hcnt_q == CNT_MAX);
      v_adv         = advance & h_wrap;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      if (advance) begin
         hcnt_d = h_wrap ? H_PRELOAD : hcnt_q + 9'd1;
      end
      if (v_adv) begin
         vcnt_d = (vcnt_q == CNT_MAX) ? V_PRELOAD : vcnt_q + 9'd1;
      end
      frame_start_d = v_adv & (vcnt_q == CNT_MAX);
      // Set has priority over a coincident ack so an IRQ is never lost.
      irq_d = irq_q;
      if (irq_ack) begin
         irq_d = 1'b0;
      end
      if (v_adv && (vcnt_d == VB_START)) begin
         irq_d = 1'b1;
      end
   end

`ifdef HSYNC_ADJ_EN
   logic signed [3:0] adj_q, adj_d;
   cnt9_t             adj_ext;

   // New adjust takes effect together with the frame that starts on this advance.
   assign adj_d    = frame_start_d ? hs_adj : adj_q;
   assign adj_ext  = {{5{adj_d[3]}}, adj_d};
   assign hs_start = HS_START + adj_ext;
   assign hs_end   = HS_END + adj_ext;

   // Adjust register; only reloads at a frame boundary so a frame never tears.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         adj_q <= '0;
      end else begin
         adj_q <= adj_d;
      end
   end
`else
   assign hs_start = HS_START;
   assign hs_end   = HS_END;
`endif

   hv_window_decode u_hblank (.cnt_i(hcnt_d), .start_i(HB_END),   .end_i(HB_START), .in_win_o(h_active));
   hv_window_decode u_hsync  (.cnt_i(hcnt_d), .start_i(hs_start), .end_i(hs_end),   .in_win_o(hs_win));
   hv_window_decode u_vblank (.cnt_i(vcnt_d), .start_i(VB_END),   .end_i(VB_START), .in_win_o(v_active));
   hv_window_decode u_vsync  (.cnt_i(vcnt_d), .start_i(VS_START), .end_i(VS_END),   .in_win_o(vs_win));

   // State registers; reset flags are the window decode of the preload counts.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         hcnt_q        <= H_PRELOAD;
         vcnt_q        <= V_PRELOAD;
         hblank_q      <= ~in_window(H_PRELOAD, HB_END, HB_START);
         hsync_q       <= in_window(H_PRELOAD, HS_START, HS_END);
         vblank_q      <= ~in_window(V_PRELOAD, VB_END, VB_START);
         vsync_q       <= in_window(V_PRELOAD, VS_START, VS_END);
         frame_start_q <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         hblank_q      <= ~h_active;
         hsync_q       <= hs_win;
         vblank_q      <= ~v_active;
         vsync_q       <= vs_win;
         frame_start_q <= frame_start_d;
         irq_q         <= irq_d;
      end
   end

   assign hcnt        = hcnt_q;
   assign vcnt        = vcnt_q;
   assign hblank      = hblank_q;
   assign hsync       = hsync_q;
   assign vblank      = vblank_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;
   assign irq_vblank  = irq_q;

endmodule

// File: tb/tb_snk_hv_timing_ctrl.sv
// Bench for snk_hv_timing_ctrl: frame shortened via V parameters so several frames fit in a short run.
// Expected values come from a pixel/line position model (px 0..383, line 0..NLINES-1).
// Checks are inline in one task per scenario, run in sequence from a single initial block.
module tb_snk_hv_timing_ctrl;

   localparam logic [8:0] H_PRE  = 9'h080;
   localparam logic [8:0] V_PRE  = 9'h1E8;
   localparam logic [8:0] VB_E   = 9'h1EA;
   localparam logic [8:0] VB_S   = 9'h1F0;
   localparam logic [8:0] VS_S   = 9'h1E8;
   localparam logic [8:0] VS_E   = 9'h1EC;
   localparam int         PXL    = 512 - 128;   // 384 pixel clocks per line
   localparam int         NLINES = 512 - 488;   // 24 lines per shortened frame

   logic       Clk = 1'b0;
   logic       Clear_bar, ce_pix, freeze, irq_ack;
`ifdef HSYNC_ADJ_EN
   logic signed [3:0] hs_adj = 4'sd0;
`endif
   logic [8:0] hcnt, vcnt;
   logic       hblank, hsync, vblank, vsync, frame_start, irq_vblank;

   int tests  = 0;
   int failed = 0;

   // Reference model state
   int   px, line, adj_m;
   logic irq_m, fs_m;

   wire [23:0] dut_vec = {hcnt, vcnt, hblank, hsync, vblank, vsync, frame_start, irq_vblank};

   snk_hv_timing_ctrl #(
      .V_PRELOAD(V_PRE), .VB_END(VB_E), .VB_START(VB_S), .VS_START(VS_S), .VS_END(VS_E)
   ) dut (
      .Clk(Clk), .Clear_bar(Clear_bar), .ce_pix(ce_pix), .freeze(freeze), .irq_ack(irq_ack),
`ifdef HSYNC_ADJ_EN
      .hs_adj(hs_adj),
`endif
      .hcnt(hcnt), .vcnt(vcnt), .hblank(hblank), .hsync(hsync), .vblank(vblank),
      .vsync(vsync), .frame_start(frame_start), .irq_vblank(irq_vblank)
   );

   always #5 Clk = ~Clk;

   function automatic logic [23:0] exp_vec();
      int   h, v;
      logic hb, hs, vb, vs;
      h  = 128 + px;
      v  = int'(V_PRE) + line;
      hb = !(h >= 'h0C0 && h < 'h1C0);
      hs = (h >= 'h088 + adj_m) && (h < 'h0A8 + adj_m);
      vb = !(v >= int'(VB_E) && v < int'(VB_S));
      vs = (v >= int'(VS_S)) && (v < int'(VS_E));
      return {9'(h), 9'(v), hb, hs, vb, vs, fs_m, irq_m};
   endfunction

   task automatic model_reset();
      px = 0; line = 0; adj_m = 0; irq_m = 1'b0; fs_m = 1'b0;
   endtask

   task automatic model_clock(input logic ce, input logic frz, input logic ack);
      logic set;
      set  = 1'b0;
      fs_m = 1'b0;
      if (ce && !frz) begin
         px++;
         if (px == PXL) begin
            px = 0;
            line++;
            if (line == NLINES) begin
               line = 0;
               fs_m = 1'b1;
`ifdef HSYNC_ADJ_EN
               adj_m = int'(hs_adj);
`endif
            end
            if (int'(V_PRE) + line == int'(VB_S)) set = 1'b1;
         end
      end
      if (set) irq_m = 1'b1;
      else if (ack) irq_m = 1'b0;
   endtask

   // One Clk: drive inputs, let the edge happen, update the model, settle before sampling.
   task automatic step(input logic ce, input logic frz, input logic ack);
      ce_pix = ce; freeze = frz; irq_ack = ack;
      @(posedge Clk);
      model_clock(ce, frz, ack);
      #1;
   endtask

   // Walk forward with ce_pix=1 until the model sits at (tl, tp); ok=0 if the budget runs out.
   task automatic goto_pos(input int tl, input int tp, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 2 * NLINES * PXL; i++) begin
         if (line == tl && px == tp) begin ok = 1'b1; break; end
         step(1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      Clear_bar = 1'b0; ce_pix = 1'b0; freeze = 1'b0; irq_ack = 1'b0;
      #12;
      model_reset();
      tests++; if (hcnt !== 9'h080)      begin failed++; $display("FAIL reset_hcnt got %h want 080", hcnt); end
      tests++; if (vcnt !== V_PRE)       begin failed++; $display("FAIL reset_vcnt got %h want %h", vcnt, V_PRE); end
      tests++; if (hblank !== 1'b1)      begin failed++; $display("FAIL reset_hblank got %b want 1", hblank); end
      tests++; if (hsync !== 1'b0)       begin failed++; $display("FAIL reset_hsync got %b want 0", hsync); end
      tests++; if (vblank !== 1'b1)      begin failed++; $display("FAIL reset_vblank got %b want 1", vblank); end
      tests++; if (vsync !== 1'b1)       begin failed++; $display("FAIL reset_vsync got %b want 1", vsync); end
      tests++; if (frame_start !== 1'b0) begin failed++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
      tests++; if (irq_vblank !== 1'b0)  begin failed++; $display("FAIL reset_irq got %b want 0", irq_vblank); end
      @(negedge Clk);
      Clear_bar = 1'b1;
   endtask

   task automatic test_line();
      int nbad = 0, last = -1, period = -1;
      logic [23:0] first_got = '0, first_exp = '0;
      for (int c = 0; c < 2 * PXL + 2; c++) begin
         step(1'b1, 1'b0, 1'b0);
         if (dut_vec !== exp_vec()) begin
            if (nbad == 0) begin first_got = dut_vec; first_exp = exp_vec(); end
            nbad++;
         end
         if (hcnt === 9'h080) begin
            if (last >= 0) period = c - last;
            last = c;
         end
      end
      tests++; if (nbad !== 0) begin failed++; $display("FAIL line_trace bad=%0d got %h want %h", nbad, first_got, first_exp); end
      tests++; if (period !== PXL) begin failed++; $display("FAIL line_period got %0d want %0d", period, PXL); end
   endtask

   task automatic test_frame_windows();
      int nbad = 0, nfs = 0, last_fs = -1, fs_period = -1;
      int hb_lo = 999, hb_hi = -1, hs_lo = 999, hs_hi = -1;
      int vb_lo = 999, vb_hi = -1, vs_lo = 999, vs_hi = -1;
      logic [8:0] v_prev, v_before_fs = '0;
      v_prev = vcnt;
      for (int c = 0; c < 2 * NLINES * PXL; c++) begin
         step(1'b1, 1'b0, 1'b0);
         if (dut_vec !== exp_vec()) nbad++;
         if (frame_start === 1'b1) begin
            nfs++;
            v_before_fs = v_prev;
            if (last_fs >= 0) fs_period = c - last_fs;
            last_fs = c;
         end
         if (hblank === 1'b0) begin hb_lo = (int'(hcnt) < hb_lo) ? int'(hcnt) : hb_lo; hb_hi = (int'(hcnt) > hb_hi) ? int'(hcnt) : hb_hi; end
         if (hsync === 1'b1)  begin hs_lo = (int'(hcnt) < hs_lo) ? int'(hcnt) : hs_lo; hs_hi = (int'(hcnt) > hs_hi) ? int'(hcnt) : hs_hi; end
         if (vblank === 1'b0) begin vb_lo = (int'(vcnt) < vb_lo) ? int'(vcnt) : vb_lo; vb_hi = (int'(vcnt) > vb_hi) ? int'(vcnt) : vb_hi; end
         if (vsync === 1'b1)  begin vs_lo = (int'(vcnt) < vs_lo) ? int'(vcnt) : vs_lo; vs_hi = (int'(vcnt) > vs_hi) ? int'(vcnt) : vs_hi; end
         v_prev = vcnt;
      end
      tests++; if (nbad !== 0) begin failed++; $display("FAIL frame_trace bad_cycles=%0d want 0", nbad); end
      tests++; if (nfs !== 2) begin failed++; $display("FAIL frame_start_count got %0d want 2", nfs); end
      tests++; if (fs_period !== NLINES * PXL) begin failed++; $display("FAIL frame_period got %0d want %0d", fs_period, NLINES * PXL); end
      tests++; if (v_before_fs !== 9'h1FF) begin failed++; $display("FAIL vcnt_before_wrap got %h want 1ff", v_before_fs); end
      tests++; if (hb_lo !== 'h0C0 || hb_hi !== 'h1BF) begin failed++; $display("FAIL hblank_window got %h..%h want 0c0..1bf", hb_lo, hb_hi); end
      tests++; if (hs_lo !== 'h088 || hs_hi !== 'h0A7) begin failed++; $display("FAIL hsync_window got %h..%h want 088..0a7", hs_lo, hs_hi); end
      tests++; if (vb_lo !== 'h1EA || vb_hi !== 'h1EF) begin failed++; $display("FAIL vblank_window got %h..%h want 1ea..1ef", vb_lo, vb_hi); end
      tests++; if (vs_lo !== 'h1E8 || vs_hi !== 'h1EB) begin failed++; $display("FAIL vsync_window got %h..%h want 1e8..1eb", vs_lo, vs_hi); end
   endtask

   task automatic test_irq();
      logic ok;
      step(1'b1, 1'b0, 1'b1);   // clear any IRQ left from earlier frames
      goto_pos(int'(VB_S) - int'(V_PRE) - 1, PXL - 1, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL irq_nav timeout got %b want 1", ok); end
      tests++; if (irq_vblank !== 1'b0) begin failed++; $display("FAIL irq_before_set got %b want 0", irq_vblank); end
      step(1'b1, 1'b0, 1'b1);   // set and ack coincide
      tests++; if (irq_vblank !== 1'b1 || vcnt !== VB_S) begin failed++; $display("FAIL irq_set_wins got irq=%b vcnt=%h want 1 %h", irq_vblank, vcnt, VB_S); end
      step(1'b1, 1'b0, 1'b1);
      tests++; if (irq_vblank !== 1'b0) begin failed++; $display("FAIL irq_ack_clear got %b want 0", irq_vblank); end
      step(1'b1, 1'b0, 1'b1);
      tests++; if (irq_vblank !== 1'b0) begin failed++; $display("FAIL irq_ack_idle got %b want 0", irq_vblank); end
      tests++; if (dut_vec !== exp_vec()) begin failed++; $display("FAIL irq_model got %h want %h", dut_vec, exp_vec()); end
   endtask

   task automatic test_freeze();
      logic ok;
      logic [23:0] held;
      int nbad = 0;
      goto_pos(NLINES - 1, PXL - 1, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL freeze_nav timeout got %b want 1", ok); end
      held = dut_vec;
      tests++; if (hcnt !== 9'h1FF || vcnt !== 9'h1FF) begin failed++; $display("FAIL freeze_pos got %h/%h want 1ff/1ff", hcnt, vcnt); end
      for (int c = 0; c < 10; c++) begin
         step(1'b1, 1'b1, 1'b0);
         if (dut_vec !== held || frame_start !== 1'b0) nbad++;
      end
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b0, 1'b0);
         if (dut_vec !== held) nbad++;
      end
      tests++; if (nbad !== 0) begin failed++; $display("FAIL freeze_hold bad_cycles=%0d want 0", nbad); end
      step(1'b1, 1'b0, 1'b0);
      tests++; if (hcnt !== 9'h080 || vcnt !== V_PRE || frame_start !== 1'b1) begin
         failed++; $display("FAIL freeze_release got %h/%h fs=%b want 080/%h fs=1", hcnt, vcnt, frame_start, V_PRE); end
      step(1'b1, 1'b0, 1'b0);
      tests++; if (hcnt !== 9'h081 || frame_start !== 1'b0) begin
         failed++; $display("FAIL freeze_single_wrap got %h fs=%b want 081 fs=0", hcnt, frame_start); end
   endtask

   task automatic test_random();
      int nbad = 0;
      logic [23:0] first_got = '0, first_exp = '0;
      for (int c = 0; c < 6000; c++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
         if (dut_vec !== exp_vec()) begin
            if (nbad == 0) begin first_got = dut_vec; first_exp = exp_vec(); end
            nbad++;
         end
      end
      tests++; if (nbad !== 0) begin failed++; $display("FAIL random_trace bad=%0d got %h want %h", nbad, first_got, first_exp); end
   endtask

   task automatic test_async_reset();
      int nbad = 0;
      for (int c = 0; c < 137; c++) step(1'b1, 1'b0, 1'b0);
      #2;
      Clear_bar = 1'b0;
      #1;
      model_reset();
      tests++; if (dut_vec !== exp_vec()) begin failed++; $display("FAIL async_reset got %h want %h", dut_vec, exp_vec()); end
      @(negedge Clk);
      Clear_bar = 1'b1;
      for (int c = 0; c < 400; c++) begin
         step(1'b1, 1'b0, 1'b0);
         if (dut_vec !== exp_vec()) nbad++;
      end
      tests++; if (nbad !== 0) begin failed++; $display("FAIL after_reset bad_cycles=%0d want 0", nbad); end
   endtask

`ifdef HSYNC_ADJ_EN
   task automatic test_hs_adj();
      logic ok;
      int lo0 = 999, hi0 = -1, lo1 = 999, hi1 = -1, nbad = 0;
      goto_pos(5, 0, ok);
      tests++; if (ok !== 1'b1) begin failed++; $display("FAIL adj_nav timeout got %b want 1", ok); end
      hs_adj = -4'sd4;
      while (line != 0 || px != 0) begin
         step(1'b1, 1'b0, 1'b0);
         if (dut_vec !== exp_vec()) nbad++;
         if (hsync === 1'b1 && frame_start !== 1'b1) begin lo0 = (int'(hcnt) < lo0) ? int'(hcnt) : lo0; hi0 = (int'(hcnt) > hi0) ? int'(hcnt) : hi0; end
      end
      for (int c = 0; c < NLINES * PXL - 1; c++) begin
         step(1'b1, 1'b0, 1'b0);
         if (dut_vec !== exp_vec()) nbad++;
         if (hsync === 1'b1) begin lo1 = (int'(hcnt) < lo1) ? int'(hcnt) : lo1; hi1 = (int'(hcnt) > hi1) ? int'(hcnt) : hi1; end
      end
      tests++; if (lo0 !== 'h088 || hi0 !== 'h0A7) begin failed++; $display("FAIL adj_cur_frame got %h..%h want 088..0a7", lo0, hi0); end
      tests++; if (lo1 !== 'h084 || hi1 !== 'h0A3) begin failed++; $display("FAIL adj_next_frame got %h..%h want 084..0a3", lo1, hi1); end
      tests++; if (nbad !== 0) begin failed++; $display("FAIL adj_trace bad_cycles=%0d want 0", nbad); end
      hs_adj = 4'sd0;
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_frame_windows();
      test_irq();
      test_freeze();
      test_random();
      test_async_reset();
`ifdef HSYNC_ADJ_EN
      test_hs_adj();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
